// File: rtl/pico_io_arbiter.sv
// PicoBlaze-style I/O arbiter: registered port decode onto N_CH peripheral
// windows, a read-back mux, and a single-source interrupt controller with
// per-channel edge-detected pending bits, a mask and a latched source index.
module pico_io_arbiter #(
  parameter int unsigned       N_CH        = 4,
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       WIN_BITS    = 2,
  parameter logic [ADDR_W-1:0] BASE        = 8'h00,
  parameter logic [ADDR_W-1:0] STATUS_ADDR = 8'hF0,
  parameter logic [ADDR_W-1:0] MASK_ADDR   = 8'hF1,
  parameter logic [ADDR_W-1:0] SRC_ADDR    = 8'hF2
) (
  input  logic                     clk,
  input  logic                     kcpsm6_reset,
  input  logic [ADDR_W-1:0]        port_id,
  input  logic [DATA_W-1:0]        out_port,
  input  logic                     write_strobe,
  input  logic                     read_strobe,
  output logic [DATA_W-1:0]        in_port,
  output logic [N_CH-1:0]          ch_sel,
  output logic [N_CH-1:0]          ch_wr,
  output logic [N_CH-1:0]          ch_rd,
  output logic [WIN_BITS-1:0]      ch_dir,
  output logic [DATA_W-1:0]        ch_wdata,
  input  logic [N_CH*DATA_W-1:0]   ch_rdata,
  input  logic [N_CH-1:0]          irq_req,
  output logic                     interrupt,
  input  logic                     interrupt_ack
);

  localparam int unsigned SrcW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned IdxW = ADDR_W - WIN_BITS;

  typedef enum logic {IrqIdle, IrqActive} irq_state_e;

  // Address decode
  logic [ADDR_W:0]     offset;
  logic [IdxW-1:0]     win_idx;
  logic [WIN_BITS-1:0] win_off;
  logic [N_CH-1:0]     hit;
  logic                is_status;
  logic                is_mask;
  logic                is_src;

  // Registered bus outputs
  logic [DATA_W-1:0]   in_port_q, rd_data;
  logic [N_CH-1:0]     ch_sel_q, ch_wr_q, ch_rd_q;
  logic [WIN_BITS-1:0] ch_dir_q, ch_dir_d;
  logic [DATA_W-1:0]   ch_wdata_q;

  // Interrupt controller state
  irq_state_e          state_q, state_d;
  logic [SrcW-1:0]     src_q, src_d, lowest;
  logic [N_CH-1:0]     pending_q, pending_d;
  logic [N_CH-1:0]     mask_q, mask_d;
  logic [N_CH-1:0]     irq_prev_q;
  logic                armed_q;
  logic [N_CH-1:0]     irq_edge;
  logic [N_CH-1:0]     eligible;
  logic [N_CH-1:0]     clr;
  logic                interrupt_q;

  // Extra MSB of offset flags port_id below BASE
  assign offset  = {1'b0, port_id} - {1'b0, BASE};
  assign win_idx = offset[ADDR_W-1:WIN_BITS];
  assign win_off = offset[WIN_BITS-1:0];

  assign is_status = (port_id == STATUS_ADDR);
  assign is_mask   = (port_id == MASK_ADDR);
  assign is_src    = (port_id == SRC_ADDR);

  // One-hot channel hit from the window index
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!offset[ADDR_W] && (32'(win_idx) == i)) begin
        hit[i] = 1'b1;
      end
    end
  end

  assign ch_dir_d = (|hit) ? win_off : '0;

  // Read-back source mux, zero-extended to DATA_W
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (hit[i]) begin
        rd_data = ch_rdata[i*DATA_W +: DATA_W];
      end
    end
    if (is_status) begin
      rd_data[N_CH-1:0] = pending_q;
    end else if (is_mask) begin
      rd_data[N_CH-1:0] = mask_q;
    end else if (is_src) begin
      rd_data[DATA_W-1] = (state_q == IrqActive);
      rd_data[SrcW-1:0] = src_q;
    end
  end

  // The first cycle after reset only samples history, so a level held high
  // across reset release is not mistaken for a fresh edge.
  assign irq_edge = irq_req & ~irq_prev_q & {N_CH{armed_q}};
  assign eligible = pending_q & mask_q;

  // Lowest-index eligible source
  always_comb begin
    lowest = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        lowest = SrcW'(i);
      end
    end
  end

  // Interrupt FSM next state, pending clear/set and mask update
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    clr     = '0;
    if (write_strobe && is_status) begin
      clr = out_port[N_CH-1:0];
    end
    case (state_q)
      IrqIdle: begin
        if (|eligible) begin
          state_d = IrqActive;
          src_d   = lowest;
        end
      end
      IrqActive: begin
        // Mask changes are ignored here; only an ack releases the source.
        if (interrupt_ack) begin
          state_d    = IrqIdle;
          clr[src_q] = 1'b1;
        end
      end
      default: state_d = IrqIdle;
    endcase
    // A same-cycle new edge beats any clear.
    pending_d = (pending_q & ~clr) | irq_edge;
    mask_d    = (write_strobe && is_mask) ? out_port[N_CH-1:0] : mask_q;
  end

  // Bus decode registers
  always_ff @(posedge clk) begin
    if (kcpsm6_reset) begin
      in_port_q  <= '0;
      ch_sel_q   <= '0;
      ch_wr_q    <= '0;
      ch_rd_q    <= '0;
      ch_dir_q   <= '0;
      ch_wdata_q <= '0;
    end else begin
      in_port_q  <= rd_data;
      ch_sel_q   <= hit;
      ch_wr_q    <= hit & {N_CH{write_strobe}};
      ch_rd_q    <= hit & {N_CH{read_strobe}};
      ch_dir_q   <= ch_dir_d;
      ch_wdata_q <= out_port;
    end
  end

  // Interrupt controller registers
  always_ff @(posedge clk) begin
    if (kcpsm6_reset) begin
      state_q     <= IrqIdle;
      src_q       <= '0;
      pending_q   <= '0;
      mask_q      <= '0;
      irq_prev_q  <= '0;
      armed_q     <= 1'b0;
      interrupt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      irq_prev_q  <= irq_req;
      armed_q     <= 1'b1;
      interrupt_q <= (state_d == IrqActive);
    end
  end

  assign in_port   = in_port_q;
  assign ch_sel    = ch_sel_q;
  assign ch_wr     = ch_wr_q;
  assign ch_rd     = ch_rd_q;
  assign ch_dir    = ch_dir_q;
  assign ch_wdata  = ch_wdata_q;
  assign interrupt = interrupt_q;

endmodule
